// File: rtl/game_pkg.sv
// Shared types and constants for the memorization-game round sequencer.
// The show-length helper keeps the level-dependent arithmetic in one place.
package game_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SHOW   = 3'd2,
    S_ENTRY  = 3'd3,
    S_CHECK  = 3'd4,
    S_RESULT = 3'd5,
    S_OVER   = 3'd6
  } state_e;

  localparam int DIGIT_W = 4;
  localparam int TIMER_W = 32;

  // Show length shrinks by one step per level and is floored at one step.
  function automatic logic [TIMER_W-1:0] show_len(
    input logic [3:0]         level,
    input logic [TIMER_W-1:0] base,
    input logic [TIMER_W-1:0] step
  );
    logic [TIMER_W-1:0] steps;
    logic [TIMER_W-1:0] cut;
    steps = {{(TIMER_W-4){1'b0}}, level} - {{(TIMER_W-1){1'b0}}, 1'b1};
    cut   = steps * step;
    if ((cut >= base) || ((base - cut) < step)) show_len = step;
    else                                        show_len = base - cut;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable 32-bit down-counter; o_done marks the last cycle of a loaded interval.
// A load of N gives N cycles, with o_done high on the Nth.
module phase_timer
  import game_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic [TIMER_W-1:0] i_load_val,
  output logic               o_done
);

  logic [TIMER_W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - {{(TIMER_W-1){1'b0}}, 1'b1};
    end
  end

  assign o_done = (r_count == {{(TIMER_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/round_sequencer.sv
// Game-flow controller: sequences LOAD/SHOW/ENTRY/CHECK/RESULT for each round,
// tracks the level, and drives the display driver from registered state.
module round_sequencer
  import game_pkg::*;
#(
  parameter int unsigned SHOW_CYCLES    = 500000000,
  parameter int unsigned SHOW_STEP      = 50000000,
  parameter int unsigned RESULT_CYCLES  = 200000000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000000,
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned MAX_LEVEL      = 9
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_key_valid,
  input  logic [3:0]  i_key_value,
  input  logic [15:0] i_target,
  output logic        o_new_target,
  output logic        o_display_phase,
  output logic [15:0] o_entry,
  output logic [2:0]  o_entry_count,
  output logic        o_result_valid,
  output logic        o_result_pass,
  output logic [3:0]  o_level,
  output logic        o_game_over,
  output logic        o_game_won,
  output logic [2:0]  o_dbg_state
);

  localparam logic [31:0] MASK_FULL   = (32'd1 << (DIGIT_W * DIGITS)) - 32'd1;
  localparam logic [15:0] ENTRY_MASK  = MASK_FULL[15:0];
  localparam logic [TIMER_W-1:0] T_TIMEOUT = TIMER_W'(TIMEOUT_CYCLES);
  localparam logic [TIMER_W-1:0] T_RESULT  = TIMER_W'(RESULT_CYCLES);

  state_e             r_state, w_state_nxt;
  logic [15:0]        r_entry, w_entry_nxt;
  logic [2:0]         r_entry_count, w_count_nxt;
  logic [3:0]         r_level, w_level_nxt;
  logic [15:0]        r_target_q, w_target_q_nxt;
  logic               r_pass, w_pass_nxt;
  logic               r_won, w_won_nxt;
  logic               w_tmr_load;
  logic [TIMER_W-1:0] w_tmr_val;
  logic               w_tmr_done;
  logic [2:0]         w_count_inc;

  phase_timer u_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_done     (w_tmr_done)
  );

  assign w_count_inc = r_entry_count + 3'd1;

  always_comb begin
    w_state_nxt    = r_state;
    w_entry_nxt    = r_entry;
    w_count_nxt    = r_entry_count;
    w_level_nxt    = r_level;
    w_target_q_nxt = r_target_q;
    w_pass_nxt     = r_pass;
    w_won_nxt      = r_won;
    w_tmr_load     = 1'b0;
    w_tmr_val      = '0;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        w_entry_nxt = '0;
        w_count_nxt = '0;
        w_tmr_load  = 1'b1;
        w_tmr_val   = show_len(r_level, TIMER_W'(SHOW_CYCLES), TIMER_W'(SHOW_STEP));
        w_state_nxt = S_SHOW;
      end
      S_SHOW: begin
        if (w_tmr_done) begin
          w_target_q_nxt = i_target;
          w_tmr_load     = 1'b1;
          w_tmr_val      = T_TIMEOUT;
          w_state_nxt    = S_ENTRY;
        end
      end
      S_ENTRY: begin
        // A key on the expiry cycle wins over the timeout.
        if (i_key_valid) begin
          w_entry_nxt = {r_entry[11:0], i_key_value};
          w_count_nxt = w_count_inc;
          w_tmr_load  = 1'b1;
          w_tmr_val   = T_TIMEOUT;
          if (w_count_inc == 3'(DIGITS)) w_state_nxt = S_CHECK;
        end else if (w_tmr_done) begin
          w_pass_nxt  = 1'b0;
          w_tmr_load  = 1'b1;
          w_tmr_val   = T_RESULT;
          w_state_nxt = S_RESULT;
        end
      end
      S_CHECK: begin
        w_pass_nxt  = ((r_entry & ENTRY_MASK) == (r_target_q & ENTRY_MASK));
        w_tmr_load  = 1'b1;
        w_tmr_val   = T_RESULT;
        w_state_nxt = S_RESULT;
      end
      S_RESULT: begin
        if (w_tmr_done) begin
          if (r_pass && (r_level < 4'(MAX_LEVEL))) begin
            w_level_nxt = r_level + 4'd1;
            w_state_nxt = S_LOAD;
          end else begin
            w_won_nxt   = r_pass;
            w_state_nxt = S_OVER;
          end
        end
      end
      S_OVER: begin
        if (i_start) begin
          w_level_nxt = 4'd1;
          w_won_nxt   = 1'b0;
          w_state_nxt = S_LOAD;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_entry       <= '0;
      r_entry_count <= '0;
      r_level       <= 4'd1;
      r_target_q    <= '0;
      r_pass        <= 1'b0;
      r_won         <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_entry       <= w_entry_nxt;
      r_entry_count <= w_count_nxt;
      r_level       <= w_level_nxt;
      r_target_q    <= w_target_q_nxt;
      r_pass        <= w_pass_nxt;
      r_won         <= w_won_nxt;
    end
  end

  assign o_new_target    = (r_state == S_LOAD);
  assign o_display_phase = (r_state == S_SHOW);
  assign o_result_valid  = (r_state == S_RESULT);
  assign o_game_over     = (r_state == S_OVER);
  assign o_entry         = r_entry;
  assign o_entry_count   = r_entry_count;
  assign o_result_pass   = r_pass;
  assign o_level         = r_level;
  assign o_game_won      = r_won;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_round_sequencer.sv
// Bench for round_sequencer with short phase lengths; results are scored
// against a queue of {pass, entry} expectations pushed as keys are driven.
module tb_round_sequencer;
  import game_pkg::*;

  localparam int SHOW_C  = 20;
  localparam int STEP_C  = 5;
  localparam int RES_C   = 8;
  localparam int TMO_C   = 30;
  localparam int MAX_LVL = 3;

  logic        clk = 1'b0;
  logic        rst, start, key_valid;
  logic [3:0]  key_value;
  logic [15:0] target;
  logic        o_new_target, o_display_phase, o_result_valid, o_result_pass;
  logic        o_game_over, o_game_won;
  logic [15:0] o_entry;
  logic [2:0]  o_entry_count, o_dbg_state;
  logic [3:0]  o_level;

  int n_checks = 0;
  int n_fail   = 0;
  logic [16:0] exp_q[$];
  logic [16:0] sb_e;
  logic        rv_prev = 1'b0;

  round_sequencer #(
    .SHOW_CYCLES(SHOW_C), .SHOW_STEP(STEP_C), .RESULT_CYCLES(RES_C),
    .TIMEOUT_CYCLES(TMO_C), .DIGITS(4), .MAX_LEVEL(MAX_LVL)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_key_valid(key_valid),
    .i_key_value(key_value), .i_target(target),
    .o_new_target(o_new_target), .o_display_phase(o_display_phase),
    .o_entry(o_entry), .o_entry_count(o_entry_count),
    .o_result_valid(o_result_valid), .o_result_pass(o_result_pass),
    .o_level(o_level), .o_game_over(o_game_over), .o_game_won(o_game_won),
    .o_dbg_state(o_dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: each rising edge of result_valid consumes one expectation.
  always @(posedge clk) begin
    #1;
    if (o_result_valid && !rv_prev) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_unexpected_result", 32'd1, 32'd0);
      end else begin
        sb_e = exp_q.pop_front();
        check_eq("sb_pass", {31'd0, o_result_pass}, {31'd0, sb_e[16]});
        check_eq("sb_entry", {16'd0, o_entry}, {16'd0, sb_e[15:0]});
      end
    end
    rv_prev = o_result_valid;
  end

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_state"}, {29'd0, o_dbg_state}, {29'd0, S_IDLE});
    check_eq({tag, "_level"}, {28'd0, o_level}, 32'd1);
    check_eq({tag, "_entry"}, {16'd0, o_entry}, 32'd0);
    check_eq({tag, "_count"}, {29'd0, o_entry_count}, 32'd0);
    check_eq({tag, "_bits"},
             {26'd0, o_new_target, o_display_phase, o_result_valid,
              o_result_pass, o_game_over, o_game_won}, 32'd0);
  endtask

  task automatic press(input logic [3:0] k);
    key_valid = 1'b1;
    key_value = k;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic do_start(input logic [3:0] exp_level);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("start_new_target", {31'd0, o_new_target}, 32'd1);
    check_eq("start_level", {28'd0, o_level}, {28'd0, exp_level});
    check_eq("start_won_clear", {31'd0, o_game_won}, 32'd0);
  endtask

  // Entered from the LOAD cycle; returns on the first cycle after the show.
  task automatic measure_show(input int exp_len);
    int n = 0;
    tick();
    while (o_display_phase && n < 200) begin
      n++;
      tick();
    end
    check_eq("show_len", n, exp_len);
  endtask

  task automatic measure_result();
    int n = 0;
    while (o_result_valid && n < 200) begin
      n++;
      tick();
    end
    check_eq("result_len", n, RES_C);
  endtask

  task automatic play_round(input logic [15:0] tgt, input logic [15:0] keys, input int exp_show);
    logic [15:0] model_e = '0;
    logic [3:0]  k;
    target = tgt;
    measure_show(exp_show);
    check_eq("entry_after_show", {16'd0, o_entry}, 32'd0);
    for (int i = 3; i >= 0; i--) begin
      k = keys[i*4 +: 4];
      model_e = {model_e[11:0], k};
      if (i == 0) exp_q.push_back({model_e == tgt, model_e});
      press(k);
    end
    check_eq("entry_value", {16'd0, o_entry}, {16'd0, model_e});
    check_eq("entry_count", {29'd0, o_entry_count}, 32'd4);
    check_eq("result_not_yet", {31'd0, o_result_valid}, 32'd0);
    tick();
    check_eq("result_two_cycles", {31'd0, o_result_valid}, 32'd1);
    measure_result();
  endtask

  initial begin
    int n;
    logic [15:0] t;
    rst = 1'b1; start = 1'b0; key_valid = 1'b0; key_value = '0; target = '0;
    tick();
    tick();
    check_reset_values("reset");
    rst = 1'b0;
    tick();
    tick();
    check_eq("idle_hold", {29'd0, o_dbg_state}, {29'd0, S_IDLE});

    // Pass at level 1, next show shortens by one step.
    do_start(4'd1);
    play_round(16'h3A7F, 16'h3A7F, SHOW_C);
    check_eq("pass_reload", {31'd0, o_new_target}, 32'd1);
    check_eq("pass_level", {28'd0, o_level}, 32'd2);

    // Fail at level 2 ends the game; display values hold.
    play_round(16'h3A7F, 16'h3A7E, SHOW_C - STEP_C);
    check_eq("fail_over", {31'd0, o_game_over}, 32'd1);
    check_eq("fail_won", {31'd0, o_game_won}, 32'd0);
    tick();
    tick();
    check_eq("over_pass_hold", {31'd0, o_result_pass}, 32'd0);
    check_eq("over_level_hold", {28'd0, o_level}, 32'd2);
    check_eq("over_entry_hold", {16'd0, o_entry}, 32'h3A7E);

    // Two keys then silence: timeout after TMO_C idle cycles.
    do_start(4'd1);
    target = 16'h1234;
    measure_show(SHOW_C);
    exp_q.push_back({1'b0, 16'h0012});
    press(4'h1);
    press(4'h2);
    n = 0;
    while (!o_result_valid && n < 200) begin
      n++;
      tick();
    end
    check_eq("timeout_wait", n, TMO_C);
    measure_result();
    check_eq("timeout_over", {31'd0, o_game_over}, 32'd1);

    // Key on the expiry cycle reloads the timer instead of timing out.
    do_start(4'd1);
    measure_show(SHOW_C);
    press(4'h1);
    repeat (TMO_C - 1) tick();
    check_eq("expiry_no_result", {31'd0, o_result_valid}, 32'd0);
    exp_q.push_back({1'b0, 16'h0012});
    press(4'h2);
    check_eq("expiry_key_count", {29'd0, o_entry_count}, 32'd2);
    check_eq("expiry_key_entry", {16'd0, o_entry}, 32'h0012);
    repeat (TMO_C - 1) tick();
    check_eq("reload_still_entry", {31'd0, o_result_valid}, 32'd0);
    tick();
    check_eq("reload_timeout", {31'd0, o_result_valid}, 32'd1);
    measure_result();

    // Win the game through every level.
    do_start(4'd1);
    for (int lvl = 1; lvl <= MAX_LVL; lvl++) begin
      t = 16'($urandom_range(0, 65535));
      play_round(t, t, SHOW_C - (lvl - 1) * STEP_C);
      if (lvl < MAX_LVL) begin
        check_eq("win_reload", {31'd0, o_new_target}, 32'd1);
        check_eq("win_level", {28'd0, o_level}, lvl + 1);
      end
    end
    check_eq("won_over", {31'd0, o_game_over}, 32'd1);
    check_eq("won_flag", {31'd0, o_game_won}, 32'd1);
    repeat (3) tick();
    check_eq("won_level_cap", {28'd0, o_level}, MAX_LVL);

    // Keys and start during SHOW are ignored; show length is unchanged.
    do_start(4'd1);
    n = 0;
    tick();
    while (o_display_phase && n < 200) begin
      n++;
      key_valid = (n == 3);
      key_value = 4'h5;
      start     = (n == 4);
      tick();
    end
    key_valid = 1'b0;
    start     = 1'b0;
    check_eq("glitch_show_len", n, SHOW_C);
    check_eq("glitch_entry", {16'd0, o_entry}, 32'd0);
    check_eq("glitch_count", {29'd0, o_entry_count}, 32'd0);
    check_eq("glitch_state", {29'd0, o_dbg_state}, {29'd0, S_ENTRY});

    // Reset mid-ENTRY and mid-SHOW.
    press(4'h4);
    rst = 1'b1;
    tick();
    check_reset_values("rst_entry");
    rst = 1'b0;
    do_start(4'd1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check_reset_values("rst_show");
    rst = 1'b0;
    tick();

    check_eq("sb_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/round_sequencer.md
# round_sequencer

Game-flow controller for the memorization game: sequences each round through show, entry, check and result phases; owns all phase timing; tracks the level. Sits between the keypad decoder, the random-number source and the seven-segment display driver. It replaces the ad-hoc show-delay logic in the top level. Its `display_phase`, `entry` and result outputs drive the display driver directly.

## Interface
- `SHOW_CYCLES`, default 500000000: show-phase length at level 1 (5 s at 100 MHz).
- `SHOW_STEP`, default 50000000: show-phase reduction per level above 1.
- `RESULT_CYCLES`, default 200000000: result-phase hold length.
- `TIMEOUT_CYCLES`, default 1000000000: maximum idle time between key presses in entry.
- `DIGITS`, default 4: digits per answer, 1..4.
- `MAX_LEVEL`, default 9: a pass at this level wins the game.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle pulse from the debounced start button.
- `key_valid`  in  1  single-cycle pulse from the keypad decoder.
- `key_value`  in  4  hex digit; valid only while `key_valid` is high.
- `target`  in  16  number to memorize, from the random source.
- `new_target`  out  1  one-cycle request for a new random number.
- `display_phase`  out  1  high while the target is shown.
- `entry`  out  16  digits entered so far, newest in [3:0].
- `entry_count`  out  3  digits entered, 0..DIGITS.
- `result_valid`  out  1  high throughout RESULT.
- `result_pass`  out  1  comparison outcome; meaningful only while `result_valid` is high.
- `level`  out  4  current level, 1..MAX_LEVEL.
- `game_over`  out  1  high in OVER.
- `game_won`  out  1  high in OVER when the game ended by a pass at MAX_LEVEL.

## Operation
- States: IDLE, LOAD, SHOW, ENTRY, CHECK, RESULT, OVER.
- Reset values:
  - state IDLE, `level` 1.
  - `entry` 0, `entry_count` 0.
  - all 1-bit outputs 0.
  - timer 0.
- IDLE: wait for `start`, then go to LOAD.
- LOAD (1 cycle): `new_target`=1; clear `entry` and `entry_count`; load the timer with the show length; go to SHOW.
- Show length = SHOW_CYCLES − (level−1)·SHOW_STEP.
  - Compute in 32-bit unsigned arithmetic.
  - Floor at SHOW_STEP, so the length is never 0 and never wraps.
- SHOW: `display_phase`=1; key presses are ignored.
  - On the timer's last cycle: latch `target` into the internal `target_q`, load the timer with TIMEOUT_CYCLES, and go to ENTRY.
- ENTRY: each `key_valid` pulse does the following in the same cycle:
  - `entry` ← {entry[11:0], key_value}.
  - `entry_count` increments.
  - the timeout timer reloads.
  - When the press makes `entry_count` reach DIGITS, go to CHECK.
- ENTRY timeout: when the timer expires with no press, go to RESULT with `result_pass`=0.
- CHECK (1 cycle): compare the low 4·DIGITS bits of `entry` and `target_q`; register the outcome into `result_pass`; load the timer with RESULT_CYCLES; go to RESULT.
- RESULT: `result_valid`=1 for RESULT_CYCLES cycles. At expiry:
  - pass and `level` < MAX_LEVEL: `level`+1, go to LOAD.
  - pass at MAX_LEVEL: `game_won`=1, go to OVER.
  - fail: go to OVER with `game_won`=0.
- OVER: `game_over` holds; `level`, `entry` and `result_pass` hold for the display.
  - `start` sets `level`=1, clears `game_won`, and goes to LOAD.
- Simultaneous and boundary events:
  - `rst` dominates everything, in any state, including mid-show or mid-entry.
  - `start` is ignored outside IDLE and OVER.
  - `key_valid` on the same cycle as timeout expiry: the key wins and the timer reloads.
  - `level` never exceeds MAX_LEVEL and never wraps.

## Timing
- Registered outputs; no combinational path from inputs to outputs.
- `start` to `new_target`: 1 cycle (IDLE→LOAD edge).
- `display_phase` goes high the cycle after LOAD and stays high exactly for the show length.
- The random source must present the new `target` no later than 1 cycle after `new_target`.
- `entry` and `entry_count` update on the edge after `key_valid`.
- Final key → `result_valid` high: 2 cycles (via CHECK).
- Timeout → `result_valid` high: 1 cycle.
- `result_valid` stays high for exactly RESULT_CYCLES cycles.

## Structure
- Package `game_pkg` holds:
  - the state enumeration, 3-bit encoding;
  - the digit width constant (4);
  - the timer width constant (32).
- One sub-module, `phase_timer`:
  - 32-bit loadable down-counter;
  - one-cycle `done` pulse on its last cycle;
  - synchronous load overrides counting.
- Used for the show, timeout and result timing; the FSM only issues loads.

## Test plan
Run with SHOW_CYCLES=20, SHOW_STEP=5, RESULT_CYCLES=8, TIMEOUT_CYCLES=30, DIGITS=4, MAX_LEVEL=3.

- Reset, then `start` → `new_target` 1 cycle later, then `display_phase` high for exactly 20 cycles, `level`=1.
- `target`=16'h3A7F; enter keys 3, A, 7, F → `entry`=16'h3A7F, `entry_count`=4, `result_valid` 2 cycles after F with `result_pass`=1; `level`=2 after 8 cycles; the next show lasts 15 cycles.
- Enter 3, A, 7, E against 3A7F → `result_pass`=0, then `game_over`=1 with `game_won`=0; `start` → LOAD with `level`=1.
- Timeout:
  - Enter 2 keys, then nothing for 30 cycles → RESULT with `result_pass`=0.
  - Key on the expiry cycle → timer reloads and no RESULT is entered.
- Pass levels 1–3 → `game_won`=1 and `game_over`=1; `level` stays at 3.
- Glitch cases:
  - `rst` mid-SHOW and mid-ENTRY → all outputs return to their reset values the next cycle.
  - `start` during SHOW → ignored.
  - Keys during SHOW → `entry` stays 0.
